cp0_exc_unit: RTL and testbench

Consumer end of the ALU's EXP_overflow/zero-result path. It takes overflow, syscall and interrupt events from the EX stage and kills the faulting write-back. It records EPC/Cause/Status, then flushes the pipeline and redirects fetch to the exception vector. It also implements ERET, MTC0/MFC0 for CP0 regs 9/11/12/13/14, and the Count/Compare timer interrupt.

---
 rtl/cp0_pkg.sv | 69 ++++++
 rtl/cp0_timer.sv | 46 ++++
 rtl/cp0_exc_unit.sv | 180 ++++++++++++++++++
 tb/tb_cp0_exc_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field layout, FSM states.
package cp0_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned IP_W   = 6;
  localparam int unsigned IM_W   = 8;

  // CP0 register numbers
  localparam logic [ADDR_W-1:0] CP0_COUNT   = 5'd9;
  localparam logic [ADDR_W-1:0] CP0_COMPARE = 5'd11;
  localparam logic [ADDR_W-1:0] CP0_STATUS  = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_CAUSE   = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_EPC     = 5'd14;

  // ExcCode values
  localparam logic [CODE_W-1:0] EXC_INT = 5'd0;
  localparam logic [CODE_W-1:0] EXC_SYS = 5'd8;
  localparam logic [CODE_W-1:0] EXC_OV  = 5'd12;

  // Status bit positions
  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned ST_IM_HI = 15;

  // Cause bit positions
  localparam int unsigned CA_EXC_LO = 2;
  localparam int unsigned CA_EXC_HI = 6;
  localparam int unsigned CA_IP_LO  = 10;
  localparam int unsigned CA_IP_HI  = 15;
  localparam int unsigned CA_BD     = 31;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } cp0_state_e;

  // Writable Status fields
  typedef struct packed {
    logic [IM_W-1:0] im;
    logic            exl;
    logic            ie;
  } status_t;

  // Assemble the architectural Status word; unimplemented bits read 0
  function automatic logic [DATA_W-1:0] status_word(input status_t s);
    logic [DATA_W-1:0] w;
    w = '0;
    w[ST_IM_HI:ST_IM_LO] = s.im;
    w[ST_EXL]            = s.exl;
    w[ST_IE]             = s.ie;
    return w;
  endfunction

  // Assemble the architectural Cause word; unimplemented bits read 0
  function automatic logic [DATA_W-1:0] cause_word(input logic bd,
                                                   input logic [IP_W-1:0] ip,
                                                   input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CA_BD]               = bd;
    w[CA_IP_HI:CA_IP_LO]   = ip;
    w[CA_EXC_HI:CA_EXC_LO] = code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky compare-match pending flag.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              timer_pend
);

  // Free-running counter; a software load replaces that cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count_we) begin
      count <= wdata;
    end else begin
      count <= count + 32'd1;
    end
  end

  // Compare register, reset to all-ones so the timer stays quiet after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare <= 32'hFFFF_FFFF;
    end else if (compare_we) begin
      compare <= wdata;
    end
  end

  // Sticky match flag; rewriting Compare acknowledges it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_pend <= 1'b0;
    end else if (compare_we) begin
      timer_pend <= 1'b0;
    end else if (count == compare) begin
      timer_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: traps overflow/syscall/interrupt, records EPC/Cause/Status,
// flushes the pipeline and redirects fetch; also handles ERET and MTC0/MFC0.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_in_ds,
  input  logic        exp_overflow,
  input  logic        ex_syscall,
  input  logic        ex_eret,
  input  logic [5:0]  ext_int,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        wb_kill,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  cp0_state_e        state_q, state_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              flush_d, redirect_valid_d;
  logic [DATA_W-1:0] redirect_pc_d;

  status_t           status_q;
  logic              bd_q;
  logic [IP_W-1:0]   ip_q;
  logic [CODE_W-1:0] exc_code_q;
  logic [DATA_W-1:0] epc_q;

  logic [DATA_W-1:0] count, compare;
  logic              timer_pend;

  logic [IP_W-1:0]   ip_eff;
  logic              run, int_pend, trap, eret_take, mtc0_take;
  logic [CODE_W-1:0] trap_code;

  assign run       = (state_q == RUN);
  assign ip_eff    = {ip_q[IP_W-1] | timer_pend, ip_q[IP_W-2:0]};
  assign int_pend  = status_q.ie & ~status_q.exl & (|(ip_eff & status_q.im[IM_W-1:2]));
  assign trap      = run & ex_valid & (int_pend | exp_overflow | ex_syscall);
  assign eret_take = run & ex_valid & ex_eret & ~trap;
  assign mtc0_take = run & mtc0_we & ~trap & ~eret_take;
  assign wb_kill   = trap;

  // Exception code by priority: interrupt, then overflow, then syscall
  always_comb begin
    trap_code = EXC_SYS;
    if (int_pend) begin
      trap_code = EXC_INT;
    end else if (exp_overflow) begin
      trap_code = EXC_OV;
    end
  end

  cp0_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (mtc0_take && (cp0_addr == CP0_COUNT)),
    .compare_we (mtc0_take && (cp0_addr == CP0_COMPARE)),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .timer_pend (timer_pend)
  );

  // Sample hardware interrupt lines into Cause.IP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q <= '0;
    end else begin
      ip_q <= ext_int;
    end
  end

  // Status/Cause/EPC update: trap beats ERET beats MTC0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q   <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else if (trap) begin
      exc_code_q   <= trap_code;
      status_q.exl <= 1'b1;
      if (!status_q.exl) begin
        epc_q <= ex_in_ds ? (ex_pc - 32'd4) : ex_pc;
        bd_q  <= ex_in_ds;
      end
    end else if (eret_take) begin
      status_q.exl <= 1'b0;
    end else if (mtc0_take) begin
      if (cp0_addr == CP0_STATUS) begin
        status_q.im  <= cp0_wdata[ST_IM_HI:ST_IM_LO];
        status_q.exl <= cp0_wdata[ST_EXL];
        status_q.ie  <= cp0_wdata[ST_IE];
      end else if (cp0_addr == CP0_EPC) begin
        epc_q <= cp0_wdata;
      end
    end
  end

  assign epc_o    = epc_q;
  assign status_o = status_word(status_q);
  assign cause_o  = cause_word(bd_q, ip_eff, exc_code_q);

  // MFC0 read mux; unmapped numbers read 0
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_COUNT:   cp0_rdata = count;
      CP0_COMPARE: cp0_rdata = compare;
      CP0_STATUS:  cp0_rdata = status_o;
      CP0_CAUSE:   cp0_rdata = cause_o;
      CP0_EPC:     cp0_rdata = epc_q;
      default:     cp0_rdata = '0;
    endcase
  end

  // Redirect/flush FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      flush_cnt_q    <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      flush          <= flush_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
    end
  end

  // Next state: a trap or ERET starts a flush window of FLUSH_CYCLES cycles
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc;
    case (state_q)
      RUN: begin
        if (trap || eret_take) begin
          state_d          = FLUSH;
          flush_cnt_d      = FLUSH_LAST;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = trap ? EXC_VECTOR : epc_q;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
          flush_d     = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit with hand-computed expectations.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_in_ds, exp_overflow, ex_syscall, ex_eret, mtc0_we;
  logic [31:0] ex_pc, cp0_wdata;
  logic [5:0]  ext_int;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_rdata, redirect_pc, epc_o, status_o, cause_o;
  logic        wb_kill, flush, redirect_valid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cp0_exc_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_in_ds       (ex_in_ds),
    .exp_overflow   (exp_overflow),
    .ex_syscall     (ex_syscall),
    .ex_eret        (ex_eret),
    .ext_int        (ext_int),
    .mtc0_we        (mtc0_we),
    .cp0_addr       (cp0_addr),
    .cp0_wdata      (cp0_wdata),
    .cp0_rdata      (cp0_rdata),
    .wb_kill        (wb_kill),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .epc_o          (epc_o),
    .status_o       (status_o),
    .cause_o        (cause_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_in_ds = 0; exp_overflow = 0; ex_syscall = 0; ex_eret = 0;
    mtc0_we = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1; cp0_addr = a; cp0_wdata = d;
  endtask

  initial begin
    idle();
    ex_pc = '0; ext_int = '0; cp0_addr = '0; cp0_wdata = '0;
    rst_n = 0;
    tick(); tick();
    check("rst_status", status_o, 32'h0);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_rv", {31'b0, redirect_valid}, 32'h0);
    check("rst_rpc", redirect_pc, 32'h0);
    cp0_addr = 5'd11; #1;
    check("rst_compare", cp0_rdata, 32'hFFFF_FFFF);
    cp0_addr = 5'd9; #1;
    check("rst_count", cp0_rdata, 32'h0);
    rst_n = 1;
    tick();

    // Overflow trap
    ex_valid = 1; ex_pc = 32'h0040_0010; exp_overflow = 1; #1;
    check("ov_wb_kill", {31'b0, wb_kill}, 32'h1);
    tick(); idle();
    check("ov_rv", {31'b0, redirect_valid}, 32'h1);
    check("ov_rpc", redirect_pc, 32'h0000_0180);
    check("ov_flush1", {31'b0, flush}, 32'h1);
    check("ov_epc", epc_o, 32'h0040_0010);
    check("ov_cause", cause_o, 32'h0000_0030);
    check("ov_status", status_o, 32'h0000_0002);
    // Events during FLUSH are ignored
    ex_valid = 1; exp_overflow = 1; ex_pc = 32'h0040_0050; #1;
    check("flush_no_kill", {31'b0, wb_kill}, 32'h0);
    tick(); idle();
    check("ov_flush2", {31'b0, flush}, 32'h1);
    check("ov_rv_pulse", {31'b0, redirect_valid}, 32'h0);
    check("flush_epc_hold", epc_o, 32'h0040_0010);
    tick();
    check("ov_flush_end", {31'b0, flush}, 32'h0);

    // Overflow in delay slot
    mtc0(5'd12, 32'h0); tick(); idle();
    check("clr_status", status_o, 32'h0);
    ex_valid = 1; ex_pc = 32'h0040_0024; ex_in_ds = 1; exp_overflow = 1;
    tick(); idle();
    check("ds_epc", epc_o, 32'h0040_0020);
    check("ds_cause", cause_o, 32'h8000_0030);
    tick(); tick();
    check("ds_flush_end", {31'b0, flush}, 32'h0);

    // Interrupt beats syscall; MFC0 shows pre-edge value during write
    mtc0(5'd12, 32'h0000_0401); ext_int = 6'b000001; #1;
    check("mfc0_pre_edge", cp0_rdata, 32'h0000_0002);
    tick(); idle();
    check("int_status_wr", status_o, 32'h0000_0401);
    ex_valid = 1; ex_syscall = 1; ex_pc = 32'h0040_0100; #1;
    check("int_wb_kill", {31'b0, wb_kill}, 32'h1);
    tick(); idle();
    check("int_cause", cause_o, 32'h0000_0400);
    check("int_epc", epc_o, 32'h0040_0100);
    check("int_status", status_o, 32'h0000_0403);
    ext_int = '0;
    tick(); tick();
    check("int_flush_end", {31'b0, flush}, 32'h0);
    check("ip_cleared", cause_o, 32'h0);

    // Nested trap with EXL=1 keeps EPC; then ERET
    mtc0(5'd14, 32'h0000_0100); tick(); idle();
    check("epc_wr", epc_o, 32'h0000_0100);
    ex_valid = 1; ex_syscall = 1; ex_pc = 32'h0000_0200;
    tick(); idle();
    check("nest_epc", epc_o, 32'h0000_0100);
    check("nest_cause", cause_o, 32'h0000_0020);
    check("nest_rpc", redirect_pc, 32'h0000_0180);
    tick(); tick();
    ex_valid = 1; ex_eret = 1; #1;
    check("eret_no_kill", {31'b0, wb_kill}, 32'h0);
    tick(); idle();
    check("eret_rv", {31'b0, redirect_valid}, 32'h1);
    check("eret_rpc", redirect_pc, 32'h0000_0100);
    check("eret_status", status_o, 32'h0000_0401);
    tick(); tick();
    check("eret_flush_end", {31'b0, flush}, 32'h0);

    // Timer
    mtc0(5'd11, 32'd5); tick();
    mtc0(5'd9, 32'd0); tick(); idle();
    cp0_addr = 5'd9; #1;
    check("count_load", cp0_rdata, 32'd0);
    repeat (5) tick();
    check("count_5", cp0_rdata, 32'd5);
    check("tp_not_yet", {31'b0, cause_o[15]}, 32'h0);
    tick();
    check("tp_set", cause_o, 32'h0000_8020);
    cp0_addr = 5'd10; #1;
    check("unmapped", cp0_rdata, 32'h0);
    mtc0(5'd11, 32'd100); tick(); idle();
    check("tp_clr", cause_o, 32'h0000_0020);

    // Trap wins over same-cycle MTC0; MTC0 in FLUSH ignored; reset mid-FLUSH
    ex_valid = 1; ex_syscall = 1; ex_pc = 32'h0040_0300;
    mtc0(5'd14, 32'hDEAD_0000);
    tick(); idle();
    check("trap_beats_mtc0", epc_o, 32'h0040_0300);
    mtc0(5'd14, 32'h0000_1234);
    tick(); idle();
    check("flush_mtc0_drop", epc_o, 32'h0040_0300);
    check("flush2_high", {31'b0, flush}, 32'h1);
    rst_n = 0; #1;
    check("arst_flush", {31'b0, flush}, 32'h0);
    check("arst_rv", {31'b0, redirect_valid}, 32'h0);
    check("arst_status", status_o, 32'h0);
    check("arst_cause", cause_o, 32'h0);
    check("arst_epc", epc_o, 32'h0);
    cp0_addr = 5'd11; #1;
    check("arst_compare", cp0_rdata, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
